instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch.sv | 101 ++++++++++
 tb/tb_instr_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, default reset vector, NOP encoding and
// the fetch-buffer entry type.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential word address; wraps 32'hFFFF_FFFC -> 32'h0 naturally.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO of {pc, instr} with synchronous flush.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DepthC);
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Credit-based instruction fetch with in-order memory port, redirect and stale-response drop.
// Optional FETCH_PERF_CNT_EN adds fetch_count, counting instructions accepted by decode.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count
`endif
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam logic [SumW-1:0] CreditMax = SumW'(BUF_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, resp_pc_q;
  logic [CntW-1:0] out_q, out_d, drop_q, fifo_cnt;
  logic [SumW-1:0] credit_sum;
  logic            gnt_fire, drop_rsp, push, pop, fifo_full, fifo_empty;
  fetch_entry_t    entry_in, head;

  always_comb begin
    credit_sum = SumW'(out_q) + SumW'(fifo_cnt);
    imem_req   = !rst && !redirect_valid && (credit_sum < CreditMax);
    gnt_fire   = imem_req && imem_gnt;
    // Responses in the redirect cycle belong to the old stream, as do drop_q later ones.
    drop_rsp   = redirect_valid || (drop_q != '0);
    push       = imem_rvalid && !drop_rsp && !fifo_full;
    pop        = instr_valid && instr_ready;
    out_d      = out_q + CntW'(gnt_fire) - CntW'(imem_rvalid);
    entry_in   = '{pc: resp_pc_q, instr: imem_rdata};
  end

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = !fifo_empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      out_q <= out_d;
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        resp_pc_q  <= redirect_pc;
        drop_q     <= out_d;
      end else begin
        if (gnt_fire) fetch_pc_q <= pc_inc(fetch_pc_q);
        if (push) resp_pc_q <= pc_inc(resp_pc_q);
        if (imem_rvalid && (drop_q != '0)) drop_q <= drop_q - CntW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(BUF_DEPTH),
    .CNT_W(CntW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .wdata(entry_in),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (pop) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: memory model with in-order variable latency,
// expected stream derived from reset/redirect targets, monitor on decoder handshakes.
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  instr_fetch #(
    .RESET_PC (RST_PC),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  typedef struct {logic [31:0] addr; int due;} pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];

  int errors = 0, checks = 0;
  int gnt_pct = 100, rdy_pct = 100, redir_pct = 0, lat_lo = 1, lat_hi = 1;
  int cycle = 0, last_due = 0, accepts = 0, acc_since_rst = 0;
  logic        force_redir = 1'b0, apply_redir = 1'b0, first_after_rst = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] force_pc, fetch_exp, gen_pc, redir_target, prev_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ NOP_INSTR;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 + (32'($urandom_range(3)) << 2);
    else t = 32'($urandom_range(1023)) << 2;
    return t;
  endfunction

  // One clock cycle: drive at posedge+1, observe at negedge.
  task automatic step();
    int due;
    @(posedge clk);
    #1;
    cycle++;
    if (apply_redir) begin
      exp_q.delete();
      gen_pc      = redir_target;
      apply_redir = 1'b0;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: gen_pc, instr: mem_word(gen_pc)});
      gen_pc += 32'd4;
    end
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end else if (!redirect_valid && ($urandom_range(99) < redir_pct)) begin
      redirect_valid = 1'b1;
      redirect_pc    = pick_target();
    end else begin
      redirect_valid = 1'b0;
    end
    if (pend_q.size() != 0 && pend_q[0].due <= cycle) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    instr_ready = ($urandom_range(99) < rdy_pct);

    @(negedge clk);
    if (first_after_rst && !redirect_valid) check("first_req_after_rst", imem_req, 1);
    first_after_rst = 1'b0;
    if (prev_stall && !redirect_valid) begin
      check("stall_req_held", imem_req, 1);
      check("stall_addr_held", imem_addr, prev_addr);
    end
    prev_stall = imem_req && !imem_gnt && !redirect_valid;
    prev_addr  = imem_addr;
    if (imem_req && imem_gnt) begin
      check("fetch_addr", imem_addr, fetch_exp);
      fetch_exp += 32'd4;
      due = cycle + int'($urandom_range(lat_hi, lat_lo));
      if (due < last_due) due = last_due;
      last_due = due;
      pend_q.push_back('{addr: imem_addr, due: due});
    end
    if (redirect_valid) begin
      check("req_low_in_redirect", imem_req, 0);
      fetch_exp    = redirect_pc;
      redir_target = redirect_pc;
      apply_redir  = 1'b1;
    end
    check("outstanding_le_depth", 32'(pend_q.size() > DEPTH), 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst            = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    pend_q.delete();
    exp_q.delete();
    fetch_exp   = RST_PC;
    gen_pc      = RST_PC;
    apply_redir = 1'b0;
    last_due    = 0;
    prev_stall  = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_fetch_count", fetch_count, 0);
`endif
    #1;
    rst             = 1'b0;
    first_after_rst = 1'b1;
  endtask

  // Monitor: every decoder handshake must match the next expected {pc, instr}.
  initial begin
    logic        prev_hold = 1'b0, prev_redir = 1'b0;
    logic [31:0] hold_pc = '0, hold_instr = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold     = 1'b0;
        prev_redir    = 1'b0;
        acc_since_rst = 0;
      end else begin
        if (prev_redir) check("valid_low_after_redirect", instr_valid, 0);
        if (prev_hold) begin
          check("hold_valid", instr_valid, 1);
          check("hold_pc", instr_pc, hold_pc);
          check("hold_instr", instr, hold_instr);
        end
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check("instr_pc", instr_pc, e.pc);
            check("instr", instr, e.instr);
          end
          accepts++;
          acc_since_rst++;
        end
        prev_hold  = instr_valid && !instr_ready && !redirect_valid;
        prev_redir = redirect_valid;
        hold_pc    = instr_pc;
        hold_instr = instr;
      end
    end
  end

  initial begin
    do_reset(2);

    // Back-to-back fetch, single-cycle memory, decoder always ready.
    repeat (12) step();

    // Decoder stalls: buffer fills, requests stop, head stays put.
    rdy_pct = 0;
    repeat (6) step();
    check("stall_buffer_valid", instr_valid, 1);
    check("stall_req_low", imem_req, 0);
    check("stall_head_pc", instr_pc, exp_q[0].pc);
    rdy_pct = 100;
    repeat (8) step();

    // Memory withholds grant for 3 cycles.
    gnt_pct = 0;
    repeat (3) step();
    gnt_pct = 100;
    repeat (4) step();

    // Redirect with two responses in flight.
    lat_lo = 3;
    lat_hi = 3;
    repeat (6) step();
    force_pc    = 32'h100;
    force_redir = 1'b1;
    step();
    repeat (15) step();

    // Redirect coinciding with a response and a pop.
    lat_lo = 1;
    lat_hi = 1;
    repeat (5) step();
    force_pc    = 32'h200;
    force_redir = 1'b1;
    step();
    repeat (10) step();

    // Randomized traffic, with a mid-run reset.
    gnt_pct   = 70;
    rdy_pct   = 70;
    redir_pct = 4;
    lat_lo    = 1;
    lat_hi    = 4;
    repeat (3000) step();
    redir_pct = 0;
    do_reset(3);
    redir_pct = 4;
    repeat (2000) step();

    redir_pct = 0;
    gnt_pct   = 100;
    rdy_pct   = 100;
    repeat (20) step();
    rdy_pct = 0;
    repeat (2) step();
    check("progress", 32'(accepts > 500), 1);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, 32'(acc_since_rst));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
